// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Brief    : Round-robin arbiter sharing one adder among NREQ requesters,
//            with a single-entry registered response and an op counter.
// Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
    parameter int WIDTH  = 8,
    parameter int SWIDTH = 9,
    parameter int NREQ   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_x,
    input  logic [NREQ*WIDTH-1:0]     req_y,
    input  logic [NREQ-1:0]           req_cin,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [SWIDTH-1:0]         rsp_sum,
    output logic                      rsp_zero,
    output logic [15:0]               op_count
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW-1:0] c_last_id = IDW'(NREQ - 1);

    logic [WIDTH-1:0]  w_x [NREQ];
    logic [WIDTH-1:0]  w_y [NREQ];

    logic              r_rsp_valid;
    logic [SWIDTH-1:0] r_rsp_sum;
    logic [IDW-1:0]    r_rsp_id;
    logic              r_rsp_zero;
    logic [15:0]       r_op_count;
    logic [IDW-1:0]    r_ptr;

    logic              w_slot_free;
    logic              w_gnt_any;
    logic [IDW-1:0]    w_gnt_idx;
    logic [IDW-1:0]    w_scan_idx;
    logic [NREQ-1:0]   w_req_ready;
    logic [SWIDTH-1:0] w_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_x[gi] = req_x[gi*WIDTH +: WIDTH];
            assign w_y[gi] = req_y[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_slot_free = ~r_rsp_valid | rsp_ready;

    // Scan upward from r_ptr with wrap; the first valid requester wins.
    always_comb begin
        w_gnt_any   = 1'b0;
        w_gnt_idx   = '0;
        w_scan_idx  = '0;
        w_req_ready = '0;
        if (en && w_slot_free) begin
            for (int k = 0; k < NREQ; k++) begin
                w_scan_idx = IDW'((int'(r_ptr) + k) % NREQ);
                if (!w_gnt_any && req_valid[w_scan_idx]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_scan_idx;
                end
            end
        end
        if (w_gnt_any) begin
            w_req_ready = NREQ'(1) << w_gnt_idx;
        end
    end

    assign w_sum = SWIDTH'(w_x[w_gnt_idx]) + SWIDTH'(w_y[w_gnt_idx])
                 + SWIDTH'(req_cin[w_gnt_idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= '0;
            r_rsp_zero  <= 1'b0;
            r_op_count  <= '0;
            r_ptr       <= '0;
        end else if (w_gnt_any) begin
            // Accept may coincide with consume: reload without a bubble.
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_sum;
            r_rsp_id    <= w_gnt_idx;
            r_rsp_zero  <= (w_sum == '0);
            r_ptr       <= (w_gnt_idx == c_last_id) ? '0 : w_gnt_idx + 1'b1;
            if (r_op_count != 16'hFFFF) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;
    assign rsp_zero  = r_rsp_zero;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter SWIDTH, default 9, sum width in bits; SHALL be >= WIDTH+1.
REQ-003 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  arbitration enable; 0 blocks new grants.
REQ-007 req_valid  input  NREQ  per-requester request valid.
REQ-008 req_x  input  NREQ*WIDTH  operand x; requester i at bits [i*WIDTH +: WIDTH].
REQ-009 req_y  input  NREQ*WIDTH  operand y; same packing as req_x.
REQ-010 req_cin  input  NREQ  per-requester carry-in.
REQ-011 req_ready  output  NREQ  one-hot grant/accept, combinational.
REQ-012 rsp_valid  output  1  response register holds a result.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_id  output  clog2(NREQ)  index of requester owning the response.
REQ-015 rsp_sum  output  SWIDTH  registered x+y+cin.
REQ-016 rsp_zero  output  1  registered flag, 1 when rsp_sum == 0.
REQ-017 op_count  output  16  number of accepted operations.

Function
REQ-018 Single shared adder; at most one request accepted per cycle.
REQ-019 A request transfers when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-020 slot_free = ~rsp_valid | rsp_ready; req_ready all-zero when en=0 or slot_free=0.
REQ-021 Otherwise req_ready SHALL be one-hot on the first valid requester scanning upward (wrapping) from index ptr.
REQ-022 After each accepted request from index g, ptr SHALL become (g+1) mod NREQ; otherwise ptr holds.
REQ-023 Sum computed zero-extended to SWIDTH: x + y + cin; no truncation for SWIDTH >= WIDTH+1.
REQ-024 Latency: accepted at edge N -> rsp_valid=1 with rsp_sum/rsp_id/rsp_zero valid after edge N.
REQ-025 rsp_valid, rsp_sum, rsp_id, rsp_zero SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-026 Response consumed (rsp_valid & rsp_ready) with no new accept -> rsp_valid clears next edge.
REQ-027 Consume and accept in same cycle -> register reloads with new result, rsp_valid stays 1 (full throughput, no bubble).
REQ-028 rsp_ready with rsp_valid=0 has no effect.
REQ-029 op_count increments by 1 per accept and saturates at 16'hFFFF.
REQ-030 en deasserted mid-stream: pending response completes normally; no new grants; ptr holds.
REQ-031 req_valid may drop without being granted; no request is latched before acceptance.

Reset
REQ-032 rst_n low SHALL immediately force rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_zero=0, op_count=0, ptr=0.
REQ-033 Reset mid-operation discards any held response; no partial result appears after release.
REQ-034 First edge after rst_n rises SHALL be a normal arbitration cycle.

Verification
REQ-035 Reset, en=1, req_valid=4'b0001, x0=3, y0=4, cin0=1, rsp_ready=1 -> req_ready=4'b0001; next cycle rsp_valid=1, rsp_sum=8, rsp_id=0, rsp_zero=0, op_count=1.
REQ-036 All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,... one per cycle; rsp_valid stays 1.
REQ-037 x=255, y=255, cin=1 -> rsp_sum=9'd511; x=0, y=0, cin=0 -> rsp_sum=0, rsp_zero=1.
REQ-038 rsp_ready=0 for 3 cycles with response held -> req_ready=0, outputs unchanged; rsp_ready=1 -> next grant same cycle, new result next edge.
REQ-039 en=0 with req_valid=4'b1111 -> no grants, op_count frozen; en=1 -> grant resumes at saved ptr.
REQ-040 rst_n pulsed low while rsp_valid=1 and rsp_ready=0 -> all outputs zero asynchronously; ptr=0 after release.
